// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register-file write decoder.
// Holds the hold-slot bundle and the one-hot decode helper.
package regfile_pkg;

  localparam int REGFILE_ADDR_W   = 5;
  localparam int REGFILE_NUM_REGS = 32;

  typedef struct packed {
    logic                      valid;
    logic [REGFILE_ADDR_W-1:0] addr;
  } hold_t;

  function automatic logic [REGFILE_NUM_REGS-1:0] onehot_decode(
    input logic [REGFILE_ADDR_W-1:0] addr
  );
    logic [REGFILE_NUM_REGS-1:0] oh;
    oh       = '0;
    oh[addr] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/regfile_addr_decode.sv
// Combinational ADDR_W-to-NUM_REGS decoder with enable.
// One instance per write port.
module regfile_addr_decode
  import regfile_pkg::*;
#(
  parameter int ADDR_W = REGFILE_ADDR_W
) (
  input  logic                 en,
  input  logic [ADDR_W-1:0]    addr,
  output logic [2**ADDR_W-1:0] onehot
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot = NUM_REGS'(1) << addr;
    end
  end

endmodule

// File: rtl/regfile_wr_decoder_mp.sv
// Multi-port registered write-enable decoder with per-port hold slots.
// Optional REGFILE_ZERO_GUARD_EN: address 0 is consumed without an enable.
module regfile_wr_decoder_mp
  import regfile_pkg::*;
#(
  parameter int ADDR_W    = REGFILE_ADDR_W,
  parameter int NUM_PORTS = 2,
  parameter int CNT_W     = 16
) (
  input  logic                            clock,
  input  logic                            ctrl_reset,
  input  logic [NUM_PORTS-1:0]            wr_valid,
  input  logic [NUM_PORTS*ADDR_W-1:0]     wr_addr,
  output logic [NUM_PORTS-1:0]            wr_ready,
  output logic [NUM_PORTS*(2**ADDR_W)-1:0] we_onehot,
  output logic [2**ADDR_W-1:0]            we_any,
  output logic [CNT_W-1:0]                collision_cnt
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int DEF_W    = $clog2(NUM_PORTS + 1);

`ifdef REGFILE_ZERO_GUARD_EN
  localparam bit ZERO_GUARD = 1'b1;
`else
  localparam bit ZERO_GUARD = 1'b0;
`endif

  hold_t [NUM_PORTS-1:0]             hold_q;
  hold_t [NUM_PORTS-1:0]             hold_d;
  logic  [NUM_PORTS-1:0]             cand_v;
  logic  [NUM_PORTS-1:0]             cand_held;
  logic  [NUM_PORTS-1:0][ADDR_W-1:0] cand_addr;
  logic  [NUM_PORTS-1:0]             issue;
  logic  [NUM_REGS-1:0]              used;
  logic  [NUM_REGS-1:0]              oh;
  logic                              zero;
  logic  [DEF_W-1:0]                 n_def;
  logic  [NUM_PORTS*NUM_REGS-1:0]    dec_oh;
  logic  [NUM_REGS-1:0]              any_d;
  logic  [CNT_W:0]                   cnt_sum;
  logic  [CNT_W-1:0]                 cnt_d;

  always_comb begin
    wr_ready  = '0;
    cand_v    = '0;
    cand_held = '0;
    cand_addr = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      wr_ready[p]  = !hold_q[p].valid && !ctrl_reset;
      cand_held[p] = hold_q[p].valid;
      cand_v[p]    = hold_q[p].valid || (wr_valid[p] && wr_ready[p]);
      cand_addr[p] = hold_q[p].valid ? hold_q[p].addr
                                     : wr_addr[p*ADDR_W +: ADDR_W];
    end
  end

  // Held entries rank ahead of fresh ones; within a class, lower port first.
  always_comb begin
    hold_d = hold_q;
    issue  = '0;
    used   = '0;
    oh     = '0;
    zero   = 1'b0;
    n_def  = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (cand_v[p] && (cand_held[p] == (pass == 0))) begin
          oh   = onehot_decode(cand_addr[p]);
          zero = ZERO_GUARD && (cand_addr[p] == '0);
          if (zero) begin
            hold_d[p].valid = 1'b0;
          end else if ((used & oh) != '0) begin
            hold_d[p].valid = 1'b1;
            hold_d[p].addr  = cand_addr[p];
            n_def           = n_def + DEF_W'(1);
          end else begin
            used            = used | oh;
            issue[p]        = 1'b1;
            hold_d[p].valid = 1'b0;
          end
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
    regfile_addr_decode #(
      .ADDR_W(ADDR_W)
    ) u_dec (
      .en    (issue[p]),
      .addr  (cand_addr[p]),
      .onehot(dec_oh[p*NUM_REGS +: NUM_REGS])
    );
  end

  always_comb begin
    any_d = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      any_d = any_d | dec_oh[p*NUM_REGS +: NUM_REGS];
    end
  end

  always_comb begin
    cnt_sum = {1'b0, collision_cnt}
            + {{(CNT_W + 1 - DEF_W){1'b0}}, n_def};
    cnt_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      hold_q        <= '0;
      we_onehot     <= '0;
      we_any        <= '0;
      collision_cnt <= '0;
    end else begin
      hold_q        <= hold_d;
      we_onehot     <= dec_oh;
      we_any        <= any_d;
      collision_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_regfile_wr_decoder_mp.sv
// Scoreboard bench for regfile_wr_decoder_mp (2 ports, 32 regs).
// Reference model works on per-port hold lists and a taken-address table.
module tb_regfile_wr_decoder_mp;

  localparam int NP = 2;
  localparam int NR = 32;

`ifdef REGFILE_ZERO_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    logic [NP*NR-1:0] we;
    logic [NR-1:0]    any;
    logic [15:0]      cnt;
  } exp_t;

  logic               clock = 1'b0;
  logic               ctrl_reset = 1'b1;
  logic [NP-1:0]      wr_valid = '0;
  logic [NP*5-1:0]    wr_addr = '0;
  logic [NP-1:0]      wr_ready;
  logic [NP*NR-1:0]   we_onehot;
  logic [NR-1:0]      we_any;
  logic [15:0]        collision_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  exp_t        sb[$];
  bit          mh_v[NP];
  logic [4:0]  mh_a[NP];
  int unsigned mcnt = 0;

  regfile_wr_decoder_mp #(
    .ADDR_W   (5),
    .NUM_PORTS(NP),
    .CNT_W    (16)
  ) dut (
    .clock        (clock),
    .ctrl_reset   (ctrl_reset),
    .wr_valid     (wr_valid),
    .wr_addr      (wr_addr),
    .wr_ready     (wr_ready),
    .we_onehot    (we_onehot),
    .we_any       (we_any),
    .collision_cnt(collision_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: rank candidates, issue first of each address, defer the rest.
  task automatic model_step(input logic rst, input logic [NP-1:0] v,
                            input logic [NP*5-1:0] a);
    exp_t e;
    bit   taken[NR];
    int   order[$];
    int   defer;
    int   p;
    logic [4:0] ad;
    e.we  = '0;
    e.any = '0;
    defer = 0;
    for (int i = 0; i < NR; i++) taken[i] = 1'b0;
    if (rst) begin
      for (int i = 0; i < NP; i++) mh_v[i] = 1'b0;
      mcnt  = 0;
      e.cnt = '0;
      sb.push_back(e);
      return;
    end
    for (int i = 0; i < NP; i++) if (mh_v[i]) order.push_back(i);
    for (int i = 0; i < NP; i++) if (!mh_v[i] && v[i]) order.push_back(i);
    foreach (order[k]) begin
      p  = order[k];
      ad = mh_v[p] ? mh_a[p] : a[p*5 +: 5];
      if (GUARD && ad == 5'd0) begin
        mh_v[p] = 1'b0;
      end else if (taken[ad]) begin
        mh_v[p] = 1'b1;
        mh_a[p] = ad;
        defer++;
      end else begin
        taken[ad]        = 1'b1;
        e.we[p*NR + ad]  = 1'b1;
        e.any[ad]        = 1'b1;
        mh_v[p]          = 1'b0;
      end
    end
    mcnt  = mcnt + defer;
    if (mcnt > 65535) mcnt = 65535;
    e.cnt = mcnt[15:0];
    sb.push_back(e);
  endtask

  task automatic cycle(input logic rst, input logic [NP-1:0] v,
                       input logic [4:0] a0, input logic [4:0] a1);
    logic [NP-1:0] er;
    @(negedge clock);
    ctrl_reset = rst;
    wr_valid   = v;
    wr_addr    = {a1, a0};
    #1;
    for (int i = 0; i < NP; i++) er[i] = !rst && !mh_v[i];
    chk("wr_ready", 64'(wr_ready), 64'(er));
    model_step(rst, v, {a1, a0});
  endtask

  task automatic post;
    @(posedge clock);
    #2;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("we_onehot", we_onehot, e.we);
        chk("we_any", 64'(we_any), 64'(e.any));
        chk("collision_cnt", 64'(collision_cnt), 64'(e.cnt));
      end
    end
  end

  initial begin : stim
    logic [4:0] ra0, ra1;
    logic [NP-1:0] rv;
    logic rr;
    for (int i = 0; i < NP; i++) begin
      mh_v[i] = 1'b0;
      mh_a[i] = '0;
    end
    repeat (3) cycle(1'b1, 2'b11, 5'd1, 5'd1);

    cycle(1'b0, 2'b01, 5'd7, 5'd0);
    post();
    chk("single_we_any", 64'(we_any), 64'h80);
    chk("single_ready", 64'(wr_ready), 64'h3);
    chk("single_cnt", 64'(collision_cnt), 64'h0);

    cycle(1'b0, 2'b11, 5'd3, 5'd3);
    post();
    chk("coll_p0", we_onehot, 64'h8);
    chk("coll_ready", 64'(wr_ready), 64'h1);
    chk("coll_cnt", 64'(collision_cnt), 64'h1);
    cycle(1'b0, 2'b00, 5'd0, 5'd0);
    post();
    chk("coll_p1", we_onehot, 64'h8 << 32);
    chk("coll_ready2", 64'(wr_ready), 64'h3);

    cycle(1'b0, 2'b11, 5'd4, 5'd9);
    post();
    chk("dual_we_any", 64'(we_any), 64'h210);
    chk("dual_cnt", 64'(collision_cnt), 64'h1);

    cycle(1'b0, 2'b11, 5'd5, 5'd5);
    cycle(1'b0, 2'b01, 5'd5, 5'd5);
    post();
    chk("held_first", we_onehot, 64'h20 << 32);
    chk("held_ready", 64'(wr_ready), 64'h2);
    chk("held_cnt", 64'(collision_cnt), 64'h3);
    cycle(1'b0, 2'b00, 5'd0, 5'd0);
    post();
    chk("held_drain", we_onehot, 64'h20);

    cycle(1'b0, 2'b11, 5'd6, 5'd6);
    cycle(1'b1, 2'b00, 5'd0, 5'd0);
    post();
    chk("rst_out", 64'(we_any), 64'h0);
    chk("rst_cnt", 64'(collision_cnt), 64'h0);
    cycle(1'b0, 2'b00, 5'd0, 5'd0);
    post();
    chk("rst_drop", we_onehot, 64'h0);
    chk("rst_ready", 64'(wr_ready), 64'h3);

    cycle(1'b0, 2'b11, 5'd0, 5'd0);
    post();
    chk("zero_cnt", 64'(collision_cnt), GUARD ? 64'h0 : 64'h1);
    chk("zero_we", we_onehot, GUARD ? 64'h0 : 64'h1);
    cycle(1'b0, 2'b00, 5'd0, 5'd0);

    ra0 = '0;
    ra1 = '0;
    for (int n = 0; n < 600; n++) begin
      rr = ($urandom_range(0, 49) == 0);
      rv = 2'($urandom);
      if (!mh_v[0]) ra0 = 5'($urandom_range(0, 7));
      if (!mh_v[1]) ra1 = 5'($urandom_range(0, 7));
      cycle(rr, rv, ra0, ra1);
    end

    cycle(1'b1, 2'b00, 5'd0, 5'd0);
    for (int n = 0; n < 65540; n++) begin
      cycle(1'b0, 2'b11, 5'd5, 5'd5);
    end
    post();
    chk("sat_cnt", 64'(collision_cnt), 64'hFFFF);
    cycle(1'b0, 2'b11, 5'd5, 5'd5);
    post();
    chk("sat_hold", 64'(collision_cnt), 64'hFFFF);

    cycle(1'b0, 2'b00, 5'd0, 5'd0);
    cycle(1'b0, 2'b00, 5'd0, 5'd0);
    repeat (3) @(posedge clock);
    #2;
    chk("sb_drained", 64'(sb.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wr_decoder_mp.md
Name: regfile_wr_decoder_mp

Overview:
- Multi-port, registered write-enable decoder for the register file; successor to the single-port 5-to-32 write decoder.
- Accepts up to NUM_PORTS write requests per cycle and decodes each address to a one-hot register enable.
- Same-address collisions in one cycle are resolved by deferring the losing port through a per-port hold slot with valid/ready backpressure.
- Sits between writeback and the register array; the registered outputs drive the per-register write enables.

Parameters:
- ADDR_W, 5, write address width; NUM_REGS = 2**ADDR_W, derived localparam, not overridable.
- NUM_PORTS, 2, number of write ports (1..4); a lower index is earlier in program order.
- CNT_W, 16, width of the saturating collision counter.

Ports:
- clock  in  1  single clock, rising edge.
- ctrl_reset  in  1  synchronous, active-high reset.
- wr_valid  in  NUM_PORTS  per-port write request.
- wr_addr  in  NUM_PORTS*ADDR_W  per-port address; port p occupies [p*ADDR_W +: ADDR_W].
- wr_ready  out  NUM_PORTS  per-port accept.
- we_onehot  out  NUM_PORTS*NUM_REGS  registered per-port one-hot enable; port p occupies [p*NUM_REGS +: NUM_REGS].
- we_any  out  NUM_REGS  registered OR of all per-port enables.
- collision_cnt  out  CNT_W  saturating count of deferrals.

Behaviour:
- Reset (synchronous, active-high): clears all hold slots, we_onehot, we_any and collision_cnt. wr_ready is 0 while ctrl_reset is high; requests presented during reset are ignored.
- Handshake:
  - wr_ready[p] = !hold_valid[p] && !ctrl_reset (combinational from state).
  - A request is accepted when wr_valid[p] && wr_ready[p].
  - Holding wr_valid with ready low is legal; the address must stay stable.
- Candidates each cycle: port p's candidate is its hold entry if hold_valid[p]; otherwise its accepted request, if any.
- Arbitration: held candidates first, in ascending port index; then fresh candidates, in ascending port index. A candidate issues unless an earlier-ranked issuing candidate has the same address. Otherwise it is deferred.
- Deferral:
  - A deferred fresh candidate is written into hold[p], setting hold_valid[p].
  - A deferred held candidate stays in hold[p].
  - collision_cnt increments by the number of deferred candidates that cycle, saturating at 2**CNT_W-1.
- Issue: a held candidate that issues clears hold_valid[p] at the same clock edge, so wr_ready[p] returns high the next cycle.
- Latency: exactly 1 cycle from issue to we_onehot. Port p's slice is the one-hot of its address when it issued, else 0. we_any is registered in the same cycle.
- At most one port drives any given register per cycle, so we_any has no multi-driver enables.
- Per-port ordering is preserved because ready is low while that port holds an entry.
- Progress: held entries outrank fresh ones, so every hold drains within NUM_PORTS cycles.
- NUM_PORTS=1: no collisions are possible, hold is never set and wr_ready is constantly 1 outside reset.
- Reset mid-deferral: the hold entry is discarded and no enable is produced for it.

Optional Feature:
- Macro REGFILE_ZERO_GUARD_EN.
- Defined:
  - Address 0 never produces an enable; the request is still accepted (consumed).
  - Address 0 never participates in collisions or increments collision_cnt.
  - we_onehot bit 0 and we_any[0] are constant 0.
- Undefined: address 0 decodes and arbitrates like any other register.

Decomposition:
- Shared package regfile_pkg holds:
  - REGFILE_ADDR_W = 5 and REGFILE_NUM_REGS = 32;
  - a hold-slot struct {valid, addr};
  - function onehot_decode(addr) returning NUM_REGS bits.
- Sub-module regfile_addr_decode: combinational ADDR_W-to-NUM_REGS decoder with an enable input, one instance per port. The top level owns arbitration, hold slots, output registers and the counter.

Test Plan:
- Reset, then port0 valid with addr=7, port1 idle:
  - next cycle we_onehot[7]=1 and we_any=32'h0000_0080;
  - wr_ready stays 2'b11;
  - collision_cnt=0.
- Same cycle, port0 addr=3 and port1 addr=3:
  - cycle+1: port0 enable bit 3 only; wr_ready[1]=0; collision_cnt=1.
  - cycle+2: port1 enable bit 3; wr_ready[1]=1.
- Same cycle, port0 addr=4 and port1 addr=9:
  - both enables appear next cycle, we_any=32'h0000_0210;
  - no deferral.
- Port1 held on addr=5 while port0 issues a fresh addr=5:
  - port1 issues first;
  - port0 is deferred with wr_ready[0]=0;
  - collision_cnt increments;
  - port0 issues the following cycle.
- Assert ctrl_reset while port1 is held:
  - next cycle all outputs are 0 and hold is cleared;
  - the held write never appears.
- With REGFILE_ZERO_GUARD_EN, both ports request addr=0:
  - both are accepted;
  - no enable is produced and collision_cnt is unchanged.
- Without the macro, the same stimulus gives a port0 enable at bit 0 and one deferral.
- Force collision_cnt to 16'hFFFF, then create a collision: the counter stays at 16'hFFFF.
